vpu_sram_responder: RTL and testbench

Wide-word SRAM bank that answers the vector unit's memory port: it accepts single-cycle read/write request pulses, completes each after a fixed latency with a one-cycle `sram_ready` pulse, and returns read data on the cycle after `sram_ready`. A secondary host port, at lower priority, preloads and inspects bank contents for DMA and test. The block sits between the VPU and on-chip vector memory as the responder end of the VPU SRAM protocol.

---
 rtl/vpu_sram_responder.sv | 130 +++++++++++++
 tb/tb_vpu_sram_responder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/vpu_sram_responder.sv
// Wide-word SRAM bank answering the VPU memory port with fixed-latency completion,
// plus a lower-priority host port for preload and inspection.
module vpu_sram_responder #(
   parameter int unsigned LANES       = 64,
   parameter int unsigned DATA_WIDTH  = 16,
   parameter int unsigned SRAM_ADDR_W = 20,
   parameter int unsigned DEPTH       = 1024,
   parameter int unsigned LATENCY     = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [SRAM_ADDR_W-1:0]        sram_addr,
   input  logic [LANES*DATA_WIDTH-1:0]   sram_wdata,
   input  logic                          sram_we,
   input  logic                          sram_re,
   output logic [LANES*DATA_WIDTH-1:0]   sram_rdata,
   output logic                          sram_ready,
   output logic                          sram_err,
   output logic                          proto_err,
   input  logic                          host_req,
   input  logic                          host_we,
   input  logic [SRAM_ADDR_W-1:0]        host_addr,
   input  logic [LANES*DATA_WIDTH-1:0]   host_wdata,
   output logic                          host_gnt,
   output logic [LANES*DATA_WIDTH-1:0]   host_rdata
);
   localparam int unsigned W    = LANES * DATA_WIDTH;
   localparam int unsigned IdxW = $clog2(DEPTH);
   localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [SRAM_ADDR_W:0] AddrLim = (SRAM_ADDR_W + 1)'(DEPTH);

   typedef enum logic {StIdle, StBusy} state_e;

   state_e                 state_q, state_d;
   logic [CntW-1:0]        cnt_q, cnt_d;
   logic [SRAM_ADDR_W-1:0] req_addr_q;
   logic [W-1:0]           req_wdata_q;
   logic                   req_we_q;
   logic [W-1:0]           sram_rdata_q, host_rdata_q;
   logic                   host_gnt_q, proto_err_q;
   logic [W-1:0]           mem [DEPTH];

   logic vpu_req, vpu_accept, complete, host_accept, req_oob, host_oob, proto_viol;

   assign vpu_req  = sram_re | sram_we;
   assign req_oob  = {1'b0, req_addr_q} >= AddrLim;
   assign host_oob = {1'b0, host_addr} >= AddrLim;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (vpu_req) begin
               state_d = StBusy;
               cnt_d   = CntW'(LATENCY - 1);
            end
         end
         StBusy: begin
            if (cnt_q == '0) state_d = StIdle;
            else             cnt_d   = cnt_q - CntW'(1);
         end
         default: state_d = StIdle;
      endcase
   end

   // A reset in the completion cycle abandons the request, so it never reports ready.
   always_comb begin
      vpu_accept  = (state_q == StIdle) && vpu_req;
      complete    = (state_q == StBusy) && (cnt_q == '0) && !rst;
      host_accept = (state_q == StIdle) && !vpu_req && host_req && !host_gnt_q;
      proto_viol  = ((state_q == StIdle) && sram_re && sram_we) ||
                    ((state_q == StBusy) && vpu_req);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         req_addr_q   <= '0;
         req_wdata_q  <= '0;
         req_we_q     <= 1'b0;
         sram_rdata_q <= '0;
         host_rdata_q <= '0;
         host_gnt_q   <= 1'b0;
         proto_err_q  <= 1'b0;
      end else begin
         if (vpu_accept) begin
            req_addr_q  <= sram_addr;
            req_wdata_q <= sram_wdata;
            req_we_q    <= sram_we;
         end
         if (complete && !req_we_q) begin
            sram_rdata_q <= req_oob ? '0 : mem[req_addr_q[IdxW-1:0]];
         end
         if (host_accept && !host_we) begin
            host_rdata_q <= host_oob ? '0 : mem[host_addr[IdxW-1:0]];
         end
         host_gnt_q <= host_accept;
         if (proto_viol) proto_err_q <= 1'b1;
      end
   end

   // Array is not reset; VPU and host writes never coincide since host only enters in IDLE.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (complete && req_we_q && !req_oob) begin
            mem[req_addr_q[IdxW-1:0]] <= req_wdata_q;
         end else if (host_accept && host_we && !host_oob) begin
            mem[host_addr[IdxW-1:0]] <= host_wdata;
         end
      end
   end

   assign sram_rdata = sram_rdata_q;
   assign sram_ready = complete;
   assign sram_err   = complete && req_oob;
   assign proto_err  = proto_err_q;
   assign host_gnt   = host_gnt_q;
   assign host_rdata = host_rdata_q;

endmodule

// File: tb/tb_vpu_sram_responder.sv
// Randomized bench for vpu_sram_responder against a transaction-level memory model.
module tb_vpu_sram_responder;
   localparam int unsigned LANES   = 64;
   localparam int unsigned DW      = 16;
   localparam int unsigned AW      = 20;
   localparam int unsigned DEPTH   = 1024;
   localparam int unsigned LATENCY = 2;
   localparam int unsigned W       = LANES * DW;
   localparam int unsigned NLOW    = 32;  // in-range addresses exercised by random traffic

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] sram_addr, host_addr;
   logic [W-1:0]  sram_wdata, host_wdata, sram_rdata, host_rdata;
   logic          sram_we, sram_re, sram_ready, sram_err, proto_err;
   logic          host_req, host_we, host_gnt;

   vpu_sram_responder #(
      .LANES(LANES), .DATA_WIDTH(DW), .SRAM_ADDR_W(AW), .DEPTH(DEPTH), .LATENCY(LATENCY)
   ) dut (
      .clk(clk), .rst(rst),
      .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_we(sram_we), .sram_re(sram_re),
      .sram_rdata(sram_rdata), .sram_ready(sram_ready), .sram_err(sram_err),
      .proto_err(proto_err),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
      .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rdata(host_rdata)
   );

   always #5 clk = ~clk;

   int unsigned  n_cmp = 0;
   int unsigned  n_err = 0;
   logic [W-1:0] mdl [DEPTH];
   logic [W-1:0] mdl_rdata;
   logic         proto_exp;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %h expected %h (low 128 bits)", tag, $time,
                  got[127:0], exp[127:0]);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [W-1:0] rand_word();
      logic [W-1:0] w;
      for (int i = 0; i < W / 32; i++) w[i*32 +: 32] = $urandom;
      return w;
   endfunction

   function automatic logic [W-1:0] mdl_read(input logic [AW-1:0] a);
      if (a >= DEPTH) return '0;
      return mdl[a];
   endfunction

   function automatic logic [AW-1:0] rand_addr();
      if ($urandom_range(0, 9) == 0) return AW'($urandom_range(DEPTH, (1 << AW) - 1));
      return AW'($urandom_range(0, NLOW - 1));
   endfunction

   task automatic check_reset_vals();
      check("rst_ready", sram_ready, 1'b0);
      check("rst_err", sram_err, 1'b0);
      check("rst_gnt", host_gnt, 1'b0);
      check("rst_proto", proto_err, 1'b0);
      check("rst_rdata", sram_rdata, '0);
      check("rst_hrdata", host_rdata, '0);
   endtask

   // Starts in an idle cycle (cycle 0), ends in cycle LATENCY+1.
   task automatic vpu_op(input logic we, input logic re, input logic [AW-1:0] a,
                         input logic [W-1:0] d, input bit poke);
      bit oob;
      oob = (a >= DEPTH);
      sram_we = we; sram_re = re; sram_addr = a; sram_wdata = d;
      if (we && re) proto_exp = 1'b1;
      tick();
      sram_we = 1'b0;
      sram_re = poke;
      if (poke) begin
         sram_addr = rand_addr();
         proto_exp = 1'b1;
      end
      for (int c = 1; c <= int'(LATENCY); c++) begin
         check("ready", sram_ready, c == int'(LATENCY));
         if (c == int'(LATENCY)) check("err", sram_err, oob);
         tick();
         sram_re = 1'b0;
      end
      if (we) begin
         if (!oob) mdl[a] = d;
      end else begin
         mdl_rdata = mdl_read(a);
      end
      check("ready_end", sram_ready, 1'b0);
      check("rdata", sram_rdata, mdl_rdata);
      check("proto", proto_err, proto_exp);
   endtask

   // Starts in an idle non-grant cycle, ends in the grant cycle.
   task automatic host_op(input logic we, input logic [AW-1:0] a, input logic [W-1:0] d);
      host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
      tick();
      host_req = 1'b0;
      check("gnt", host_gnt, 1'b1);
      if (we) begin
         if (a < DEPTH) mdl[a] = d;
      end else begin
         check("hrdata", host_rdata, mdl_read(a));
      end
      check("h_no_err", sram_err, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [W-1:0] p, old_val;
      bit           last_host;
      int           kind;
      logic         we, re;

      rst = 1'b1; sram_we = 0; sram_re = 0; sram_addr = '0; sram_wdata = '0;
      host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
      proto_exp = 1'b0; mdl_rdata = '0;
      tick(); tick();
      rst = 1'b0;
      check_reset_vals();

      for (int a = 0; a < int'(NLOW); a++) begin
         host_op(1'b1, AW'(a), rand_word());
         tick();
      end

      // Host preload of 0xA5A5 then VPU read of address 5.
      p = {LANES{16'hA5A5}};
      host_op(1'b1, AW'(5), p);
      tick();
      vpu_op(1'b0, 1'b1, AW'(5), '0, 1'b0);
      check("a5a5", sram_rdata, p);

      // VPU write then read of address 10, then host read.
      p = rand_word();
      vpu_op(1'b1, 1'b0, AW'(10), p, 1'b0);
      vpu_op(1'b0, 1'b1, AW'(10), '0, 1'b0);
      check("rd10", sram_rdata, p);
      host_op(1'b0, AW'(10), '0);
      tick();

      // Out-of-range read at DEPTH.
      vpu_op(1'b0, 1'b1, AW'(DEPTH), '0, 1'b0);

      // Same-cycle VPU read and host read: VPU first, host granted in cycle LATENCY+2.
      sram_re = 1'b1; sram_addr = AW'(7);
      host_req = 1'b1; host_we = 1'b0; host_addr = AW'(10);
      tick();
      sram_re = 1'b0;
      for (int c = 1; c <= int'(LATENCY) + 1; c++) begin
         check("col_gnt", host_gnt, 1'b0);
         check("col_ready", sram_ready, c == int'(LATENCY));
         tick();
      end
      host_req = 1'b0;
      mdl_rdata = mdl[7];
      check("col_gnt_hi", host_gnt, 1'b1);
      check("col_hrdata", host_rdata, mdl[10]);
      check("col_rdata", sram_rdata, mdl_rdata);
      tick();

      // Host request held across the grant: no acceptance in the grant cycle.
      host_req = 1'b1; host_we = 1'b0; host_addr = AW'(3);
      tick();
      check("held_g1", host_gnt, 1'b1);
      tick();
      check("held_g0", host_gnt, 1'b0);
      tick();
      host_req = 1'b0;
      check("held_g2", host_gnt, 1'b1);
      tick();

      // Protocol violations: request while busy, then re and we together.
      vpu_op(1'b0, 1'b1, AW'(12), '0, 1'b1);
      p = rand_word();
      vpu_op(1'b1, 1'b1, AW'(13), p, 1'b0);
      vpu_op(1'b0, 1'b1, AW'(13), '0, 1'b0);
      check("rewe_wr", sram_rdata, p);

      last_host = 1'b0;
      for (int i = 0; i < 300; i++) begin
         kind = $urandom_range(0, 9);
         if (last_host && (kind >= 6 || $urandom_range(0, 1) == 1)) tick();
         if (kind < 6) begin
            we = 1'($urandom_range(0, 1));
            re = !we || ($urandom_range(0, 15) == 0);
            vpu_op(we, re, rand_addr(), rand_word(), $urandom_range(0, 7) == 0);
            last_host = 1'b0;
         end else begin
            host_op(1'($urandom_range(0, 1)), rand_addr(), rand_word());
            last_host = 1'b1;
         end
      end
      if (last_host) tick();

      // Reset during a pending write: no ready, old contents retained.
      old_val = mdl[20];
      sram_we = 1'b1; sram_addr = AW'(20); sram_wdata = ~old_val;
      tick();
      sram_we = 1'b0;
      rst = 1'b1;
      check("rst_busy_ready", sram_ready, 1'b0);
      tick();
      rst = 1'b0;
      proto_exp = 1'b0;
      mdl_rdata = '0;
      check_reset_vals();
      host_op(1'b0, AW'(20), '0);
      tick();
      vpu_op(1'b0, 1'b1, AW'(20), '0, 1'b0);
      check("rst_keep", sram_rdata, old_val);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
